sdram_arbit: RTL and testbench
==============================

# sdram_arbit

SDRAM command arbiter between the initialization, auto-refresh, write and read sub-controllers. It waits for power-up initialization to finish, then grants the SDRAM bus to one sub-controller at a time:
- Refresh always has priority.
- Writes and reads alternate round-robin when both are pending.

The granted module's command and address are multiplexed onto the SDRAM pins. The block also flags refresh requests that have waited too long behind a data burst.

## Interface
- REF_LATE_MAX, 250: cycles a pending ref_req may wait outside ARBIT before ref_late is set.
- sclk  in  1  system clock; all logic is on the rising edge.
- s_rst  in  1  reset, synchronous, active-high.
- flag_init_end  in  1  init sequence done; level, stays high.
- init_cmd  in  4  init module command {cs_n,ras_n,cas_n,we_n}.
- init_addr  in  13  init module address.
- ref_req  in  1  refresh request from the auto-refresh module.
- flag_ref_end  in  1  refresh sequence done.
- aref_cmd  in  4  refresh command.
- aref_addr  in  13  refresh address.
- wr_req  in  1  write request.
- flag_wr_end  in  1  write burst done.
- wr_cmd  in  4  write command.
- wr_addr  in  13  write address.
- rd_req  in  1  read request.
- flag_rd_end  in  1  read burst done.
- rd_cmd  in  4  read command.
- rd_addr  in  13  read address.
- ref_en  out  1  refresh grant.
- wr_en  out  1  write grant.
- rd_en  out  1  read grant.
- sdram_cke  out  1  clock enable, constant 1.
- sdram_cmd  out  4  muxed command to the SDRAM pins.
- sdram_addr  out  13  muxed address to the SDRAM pins.
- ref_late  out  1  sticky late-refresh error.

## Operation
**States:** INIT, ARBIT, AREF, WRITE, READ, held in a registered state register.

**Transitions:**
- INIT -> ARBIT when flag_init_end=1.
- ARBIT, decided each cycle in priority order:
  - ref_req=1 -> AREF.
  - Else wr_req and rd_req both 1 -> the one not served last.
  - Else wr_req -> WRITE.
  - Else rd_req -> READ.
  - Else stay in ARBIT.
- AREF -> ARBIT on flag_ref_end=1.
- WRITE -> ARBIT on flag_wr_end=1.
- READ -> ARBIT on flag_rd_end=1.
- Bursts are never preempted. A ref_req arriving during WRITE/READ waits for that module's end flag.

**Round-robin:**
- last_rd is a 1-bit register. It is set on entry to READ and cleared on entry to WRITE.
- Reset value is 1, so the first contested grant goes to write.
- A refresh grant does not change last_rd.

**Grants:** ref_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ). All are decoded from the state register. Each grant is high for the whole state, including the cycle in which the end flag is high.

**Mux:** combinational from the state register.
- INIT -> init_cmd / init_addr.
- AREF -> aref_cmd / aref_addr.
- WRITE -> wr_cmd / wr_addr.
- READ -> rd_cmd / rd_addr.
- ARBIT -> NOP 4'b0111 / 13'd0.

**Late-refresh check:**
- late_cnt (8 bits, saturating) increments each cycle while ref_req=1 and state is WRITE or READ.
- It clears when state==AREF.
- When late_cnt reaches REF_LATE_MAX, ref_late is set.
- ref_late clears only on reset.

**End flags outside their state are ignored.** For example, flag_wr_end in ARBIT has no effect.

## Timing
**Reset:**
- s_rst=1 at an edge gives: state=INIT, last_rd=1, late_cnt=0, ref_late=0.
- ref_en, wr_en and rd_en are 0 from the first edge with s_rst high. sdram_cmd/sdram_addr then follow init_cmd/init_addr. sdram_cke=1 always.
- Reset mid-burst aborts immediately: the grant drops at that edge and no end flag is required.

**Grant latency:** a request sampled high in ARBIT at edge N gives the grant high after edge N, i.e. a one-cycle decision.

**Release:** end flag high at edge M -> state is ARBIT after edge M and the grant drops. The earliest next grant is after edge M+1, giving a minimum one-cycle NOP gap between operations.

**Simultaneous events:**
- ref_req together with wr_req and rd_req in ARBIT -> AREF.
- An end flag together with a new request -> return to ARBIT first, then grant on the next edge.

**INIT exit:** flag_init_end sampled at edge K -> ARBIT after edge K. While in INIT, all requests are ignored.

## Test plan
1. **Reset, then init:**
   - Stimulus: hold s_rst 3 cycles, release; raise flag_init_end at cycle 10; raise wr_req at cycle 12.
   - Required response:
     - All enables stay 0 while flag_init_end=0.
     - sdram_cmd equals init_cmd while in INIT.
     - After flag_init_end, sdram_cmd=4'b0111.
     - wr_en=1 one cycle after wr_req is sampled in ARBIT.
2. **Refresh priority:**
   - Stimulus: in ARBIT, raise ref_req, wr_req and rd_req in the same cycle.
   - Required response:
     - ref_en=1 next cycle.
     - sdram_cmd follows aref_cmd.
     - On flag_ref_end, ref_en drops; after the ARBIT cycle, wr_en=1.
3. **Round-robin:**
   - Stimulus: hold wr_req and rd_req high continuously; pulse the respective end flag 4 cycles after each grant.
   - Required response: grants go WRITE, READ, WRITE, READ, with exactly one NOP cycle between them.
4. **No preemption, plus late flag with REF_LATE_MAX=4:**
   - Stimulus: during WRITE, raise ref_req and hold it; delay flag_wr_end 10 cycles.
   - Required response:
     - wr_en stays 1 until flag_wr_end.
     - ref_late rises once late_cnt reaches 4, and stays 1 after the refresh.
     - AREF follows the WRITE.
5. **Reset mid-read:**
   - Stimulus: assert s_rst while rd_en=1.
   - Required response:
     - rd_en=0 and state=INIT after that edge.
     - ref_late=0.
     - After reset is released, sdram_cmd follows init_cmd.
6. **Stray end flags:**
   - Stimulus: pulse flag_rd_end and flag_ref_end while in WRITE.
   - Required response: the state remains WRITE and wr_en stays 1.

Source files
------------

// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - sub-controller and SDRAM pin bundle for the command arbiter
interface sdram_arbit_if;
    logic        flag_init_end;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        ref_req;
    logic        flag_ref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic        wr_req;
    logic        flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic        rd_req;
    logic        flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic        ref_en;
    logic        wr_en;
    logic        rd_en;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic        ref_late;

    // Arbiter side
    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        input  ref_req, flag_ref_end, aref_cmd, aref_addr,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr,
        input  rd_req, flag_rd_end, rd_cmd, rd_addr,
        output ref_en, wr_en, rd_en,
        output sdram_cke, sdram_cmd, sdram_addr, ref_late
    );

    // Sub-controller / pin side
    modport master (
        output flag_init_end, init_cmd, init_addr,
        output ref_req, flag_ref_end, aref_cmd, aref_addr,
        output wr_req, flag_wr_end, wr_cmd, wr_addr,
        output rd_req, flag_rd_end, rd_cmd, rd_addr,
        input  ref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cmd, sdram_addr, ref_late
    );
endinterface

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter: init, refresh priority, write/read round-robin
module sdram_arbit #(
    parameter int REF_LATE_MAX = 250
) (
    input  logic          sclk,
    input  logic          s_rst,
    sdram_arbit_if.slave  bus
);
    typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;

    state_t      state;
    state_t      state_nxt;
    logic        last_rd;
    logic [7:0]  late_cnt;
    logic        ref_late_r;

    // State register; reset aborts any burst in progress
    always_ff @(posedge sclk) begin
        if (s_rst) state <= INIT;
        else       state <= state_nxt;
    end

    // Next-state: refresh first, then write/read alternating when both pend
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:  if (bus.flag_init_end) state_nxt = ARBIT;
            ARBIT: begin
                if (bus.ref_req)                    state_nxt = AREF;
                else if (bus.wr_req && bus.rd_req)  state_nxt = last_rd ? WRITE : READ;
                else if (bus.wr_req)                state_nxt = WRITE;
                else if (bus.rd_req)                state_nxt = READ;
                else                                state_nxt = ARBIT;
            end
            AREF:  if (bus.flag_ref_end) state_nxt = ARBIT;
            WRITE: if (bus.flag_wr_end)  state_nxt = ARBIT;
            READ:  if (bus.flag_rd_end)  state_nxt = ARBIT;
            default: state_nxt = INIT;
        endcase
    end

    // Remember which data module was served last; refresh leaves it untouched
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            last_rd <= 1'b1;
        end else if (state == ARBIT) begin
            if (state_nxt == READ)       last_rd <= 1'b1;
            else if (state_nxt == WRITE) last_rd <= 1'b0;
        end
    end

    // Count cycles a refresh request is stalled behind a data burst
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            late_cnt <= 8'd0;
        end else if (state == AREF) begin
            late_cnt <= 8'd0;
        end else if (bus.ref_req && (state == WRITE || state == READ) && late_cnt != 8'hFF) begin
            late_cnt <= late_cnt + 8'd1;
        end
    end

    // Sticky late-refresh error, cleared only by reset
    always_ff @(posedge sclk) begin
        if (s_rst)                                 ref_late_r <= 1'b0;
        else if (32'(late_cnt) >= REF_LATE_MAX)    ref_late_r <= 1'b1;
    end

    // Grants decoded straight from the state register
    always_comb begin
        bus.ref_en    = (state == AREF);
        bus.wr_en     = (state == WRITE);
        bus.rd_en     = (state == READ);
        bus.sdram_cke = 1'b1;
        bus.ref_late  = ref_late_r;
    end

    // Pin mux: the owner of the bus drives command and address
    always_comb begin
        bus.sdram_cmd  = CMD_NOP;
        bus.sdram_addr = 13'd0;
        case (state)
            INIT:  begin bus.sdram_cmd = bus.init_cmd; bus.sdram_addr = bus.init_addr; end
            AREF:  begin bus.sdram_cmd = bus.aref_cmd; bus.sdram_addr = bus.aref_addr; end
            WRITE: begin bus.sdram_cmd = bus.wr_cmd;   bus.sdram_addr = bus.wr_addr;   end
            READ:  begin bus.sdram_cmd = bus.rd_cmd;   bus.sdram_addr = bus.rd_addr;   end
            default: begin bus.sdram_cmd = CMD_NOP; bus.sdram_addr = 13'd0; end
        endcase
    end
endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed plus random check of sdram_arbit against a reference model
module tb_sdram_arbit;
    localparam int LATE_MAX = 4;

    // Model owners of the SDRAM bus
    localparam int O_INIT = 0;
    localparam int O_NONE = 1;
    localparam int O_REF  = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;

    logic sclk = 1'b0;
    logic s_rst;
    always #5 sclk = ~sclk;

    sdram_arbit_if bus();

    sdram_arbit #(.REF_LATE_MAX(LATE_MAX)) dut (
        .sclk  (sclk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m_owner;
    bit m_last_rd;
    int m_wait;
    bit m_late;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: who owns the bus after this edge, from the arbitration rules
    task automatic model_edge();
        int nxt;
        nxt = m_owner;
        if (s_rst) begin
            m_owner = O_INIT; m_last_rd = 1'b1; m_wait = 0; m_late = 1'b0;
            return;
        end
        if (m_wait >= LATE_MAX) m_late = 1'b1;
        if (m_owner == O_REF) m_wait = 0;
        else if (bus.ref_req && (m_owner == O_WR || m_owner == O_RD))
            m_wait = (m_wait < 255) ? m_wait + 1 : 255;
        case (m_owner)
            O_INIT: if (bus.flag_init_end) nxt = O_NONE;
            O_NONE: begin
                if (bus.ref_req)                  nxt = O_REF;
                else if (bus.wr_req && bus.rd_req) nxt = m_last_rd ? O_WR : O_RD;
                else if (bus.wr_req)              nxt = O_WR;
                else if (bus.rd_req)              nxt = O_RD;
            end
            O_REF: if (bus.flag_ref_end) nxt = O_NONE;
            O_WR:  if (bus.flag_wr_end)  nxt = O_NONE;
            O_RD:  if (bus.flag_rd_end)  nxt = O_NONE;
            default: nxt = O_INIT;
        endcase
        if (m_owner == O_NONE && nxt == O_WR) m_last_rd = 1'b0;
        if (m_owner == O_NONE && nxt == O_RD) m_last_rd = 1'b1;
        m_owner = nxt;
    endtask

    task automatic compare_all();
        logic [3:0]  ecmd;
        logic [12:0] eaddr;
        case (m_owner)
            O_INIT:  begin ecmd = bus.init_cmd; eaddr = bus.init_addr; end
            O_REF:   begin ecmd = bus.aref_cmd; eaddr = bus.aref_addr; end
            O_WR:    begin ecmd = bus.wr_cmd;   eaddr = bus.wr_addr;   end
            O_RD:    begin ecmd = bus.rd_cmd;   eaddr = bus.rd_addr;   end
            default: begin ecmd = 4'b0111;      eaddr = 13'd0;         end
        endcase
        check("ref_en",     16'(bus.ref_en),     16'(m_owner == O_REF));
        check("wr_en",      16'(bus.wr_en),      16'(m_owner == O_WR));
        check("rd_en",      16'(bus.rd_en),      16'(m_owner == O_RD));
        check("sdram_cke",  16'(bus.sdram_cke),  16'(1));
        check("sdram_cmd",  16'(bus.sdram_cmd),  16'(ecmd));
        check("sdram_addr", 16'(bus.sdram_addr), 16'(eaddr));
        check("ref_late",   16'(bus.ref_late),   16'(m_late));
    endtask

    // One clock: fresh payloads, edge, model update, compare off the edge
    task automatic tick();
        bus.init_cmd  = 4'($urandom); bus.init_addr = 13'($urandom);
        bus.aref_cmd  = 4'($urandom); bus.aref_addr = 13'($urandom);
        bus.wr_cmd    = 4'($urandom); bus.wr_addr   = 13'($urandom);
        bus.rd_cmd    = 4'($urandom); bus.rd_addr   = 13'($urandom);
        @(posedge sclk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Wait for any grant; report which one and how many ticks it took
    task automatic wait_grant(input string tag, output int who, output int gap);
        bit got;
        got = 1'b0; who = O_NONE; gap = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            gap++;
            if (bus.ref_en)     begin got = 1'b1; who = O_REF; end
            else if (bus.wr_en) begin got = 1'b1; who = O_WR;  end
            else if (bus.rd_en) begin got = 1'b1; who = O_RD;  end
        end
        check({tag, "_grant_seen"}, 16'(got), 16'(1));
    endtask

    task automatic pulse_end(input int who);
        bus.flag_ref_end = (who == O_REF);
        bus.flag_wr_end  = (who == O_WR);
        bus.flag_rd_end  = (who == O_RD);
        tick();
        bus.flag_ref_end = 1'b0; bus.flag_wr_end = 1'b0; bus.flag_rd_end = 1'b0;
    endtask

    initial begin
        int who;
        int gap;
        int prev;

        m_owner = O_INIT; m_last_rd = 1'b1; m_wait = 0; m_late = 1'b0;
        s_rst = 1'b1;
        bus.flag_init_end = 1'b0;
        bus.ref_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.flag_ref_end = 1'b0; bus.flag_wr_end = 1'b0; bus.flag_rd_end = 1'b0;

        // 1: reset, then init; requests in INIT are ignored
        for (int i = 0; i < 3; i++) tick();
        s_rst = 1'b0;
        for (int i = 3; i < 10; i++) begin
            bus.wr_req = 1'($urandom); bus.rd_req = 1'($urandom); bus.ref_req = 1'($urandom);
            tick();
            check("t1_no_grant_in_init", 16'({bus.ref_en, bus.wr_en, bus.rd_en}), 16'(0));
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.ref_req = 1'b0;
        bus.flag_init_end = 1'b1;
        tick();
        check("t1_nop_after_init", 16'(bus.sdram_cmd), 16'(4'b0111));
        tick();
        bus.wr_req = 1'b1;
        tick();
        check("t1_wr_en", 16'(bus.wr_en), 16'(1));
        bus.wr_req = 1'b0;
        tick(); tick();
        pulse_end(O_WR);

        // 2: refresh wins a three-way contest; write follows
        bus.ref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        tick();
        check("t2_ref_en", 16'(bus.ref_en), 16'(1));
        check("t2_aref_cmd", 16'(bus.sdram_cmd), 16'(bus.aref_cmd));
        bus.ref_req = 1'b0; bus.rd_req = 1'b0;
        tick(); tick();
        pulse_end(O_REF);
        check("t2_ref_dropped", 16'(bus.ref_en), 16'(0));
        tick();
        check("t2_wr_after_ref", 16'(bus.wr_en), 16'(1));
        tick(); tick(); tick();
        pulse_end(O_WR);

        // 3: round-robin with both pending; last served was write
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        prev = O_WR;
        for (int b = 0; b < 4; b++) begin
            wait_grant("t3", who, gap);
            check("t3_alternates", 16'(who), 16'((prev == O_WR) ? O_RD : O_WR));
            check("t3_one_nop_gap", 16'(gap), 16'(1));
            prev = who;
            tick(); tick(); tick();
            pulse_end(who);
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        tick();

        // 4: refresh waits behind a long write and raises ref_late
        bus.wr_req = 1'b1;
        wait_grant("t4", who, gap);
        bus.wr_req = 1'b0;
        bus.ref_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_wr_held", 16'(bus.wr_en), 16'(1));
        end
        check("t4_late_set", 16'(bus.ref_late), 16'(1));
        pulse_end(O_WR);
        tick();
        check("t4_aref_follows", 16'(bus.ref_en), 16'(1));
        bus.ref_req = 1'b0;
        tick();
        pulse_end(O_REF);
        tick();
        check("t4_late_sticky", 16'(bus.ref_late), 16'(1));

        // 5: reset in the middle of a read
        bus.rd_req = 1'b1;
        wait_grant("t5", who, gap);
        bus.rd_req = 1'b0;
        tick();
        s_rst = 1'b1;
        tick();
        check("t5_rd_dropped", 16'(bus.rd_en), 16'(0));
        check("t5_late_cleared", 16'(bus.ref_late), 16'(0));
        check("t5_init_cmd", 16'(bus.sdram_cmd), 16'(bus.init_cmd));
        s_rst = 1'b0;
        tick();
        tick();

        // 6: stray end flags during a write are ignored
        bus.wr_req = 1'b1;
        wait_grant("t6", who, gap);
        bus.wr_req = 1'b0;
        pulse_end(O_RD);
        check("t6_wr_after_rd_end", 16'(bus.wr_en), 16'(1));
        pulse_end(O_REF);
        check("t6_wr_after_ref_end", 16'(bus.wr_en), 16'(1));
        pulse_end(O_WR);

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            bus.ref_req      = ($urandom_range(0, 7) == 0);
            bus.wr_req       = ($urandom_range(0, 2) == 0);
            bus.rd_req       = ($urandom_range(0, 2) == 0);
            bus.flag_ref_end = ($urandom_range(0, 3) == 0);
            bus.flag_wr_end  = ($urandom_range(0, 5) == 0);
            bus.flag_rd_end  = ($urandom_range(0, 5) == 0);
            s_rst            = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
